// File: rtl/select_max_scan_pkg.sv
// Shared types and helpers for the select_max_scan block.
package select_max_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Equal values keep the earlier (lower-index) candidate.
  localparam bit TIE_LOW_INDEX = 1'b1;

  // Index width for n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/select_max_scan_if.sv
// Handshake / data bundle for select_max_scan.
// SELECT_MAX_MARGIN_EN adds runner_up and margin.
interface select_max_scan_if #(
  parameter int DATA_W = 16,
  parameter int NUM_IN = 10
) ();
  localparam int IDX_W = select_max_pkg::idx_w(NUM_IN);

  logic                     enable;
  logic                     start;
  logic signed [DATA_W-1:0] in_data [NUM_IN];
  logic                     busy;
  logic                     layer_done;
  logic signed [DATA_W-1:0] max;
  logic [IDX_W-1:0]         digit;
`ifdef SELECT_MAX_MARGIN_EN
  logic signed [DATA_W-1:0] runner_up;
  logic [DATA_W:0]          margin;

  modport master (output enable, start, in_data,
                  input  busy, layer_done, max, digit, runner_up, margin);
  modport slave  (input  enable, start, in_data,
                  output busy, layer_done, max, digit, runner_up, margin);
`else
  modport master (output enable, start, in_data,
                  input  busy, layer_done, max, digit);
  modport slave  (input  enable, start, in_data,
                  output busy, layer_done, max, digit);
`endif
endinterface

// File: rtl/select_max_scan_lane_tree.sv
// Combinational signed argmax over N candidates with a valid mask.
// Earlier positions win ties. With SELECT_MAX_MARGIN_EN it also returns
// the largest value at any position other than the winner.
module select_max_lane_tree import select_max_pkg::*; #(
  parameter  int DATA_W = 16,
  parameter  int N      = 3,
  localparam int PW     = idx_w(N)
) (
  input  logic [N-1:0][DATA_W-1:0] val,
  input  logic [N-1:0]             vld,
  output logic [DATA_W-1:0]        top_val,
  output logic [PW-1:0]            top_pos
`ifdef SELECT_MAX_MARGIN_EN
  ,
  output logic [DATA_W-1:0]        sec_val,
  output logic                     sec_vld
`endif
);

  function automatic logic beats(input logic signed [DATA_W-1:0] a,
                                 input logic signed [DATA_W-1:0] b);
    return TIE_LOW_INDEX ? (a > b) : (a >= b);
  endfunction

  logic top_vld;

  // Winner: first valid candidate not beaten by any later one.
  always_comb begin
    top_vld = 1'b0;
    top_val = '0;
    top_pos = '0;
    for (int i = 0; i < N; i++) begin
      if (vld[PW'(i)] && (!top_vld || beats(val[PW'(i)], top_val))) begin
        top_vld = 1'b1;
        top_val = val[PW'(i)];
        top_pos = PW'(i);
      end
    end
  end

`ifdef SELECT_MAX_MARGIN_EN
  // Runner-up: same scan with the winning position masked out.
  always_comb begin
    sec_vld = 1'b0;
    sec_val = '0;
    for (int i = 0; i < N; i++) begin
      if (vld[PW'(i)] && (PW'(i) != top_pos) &&
          (!sec_vld || beats(val[PW'(i)], sec_val))) begin
        sec_vld = 1'b1;
        sec_val = val[PW'(i)];
      end
    end
  end
`endif

endmodule

// File: rtl/select_max_scan.sv
// Multi-cycle signed argmax: snapshot a vector on start, scan LANES
// elements per enabled cycle, publish max/digit with a one-cycle
// layer_done pulse. SELECT_MAX_MARGIN_EN adds runner_up/margin.
module select_max_scan import select_max_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int NUM_IN = 10,
  parameter int LANES  = 2
) (
  input logic              clk,
  input logic              reset,
  select_max_scan_if.slave bus
);
  localparam int IDX_W = idx_w(NUM_IN);
`ifdef SELECT_MAX_MARGIN_EN
  localparam int OFF = 2;   // running best + running second ride in front
`else
  localparam int OFF = 1;   // running best rides in front of the lanes
`endif
  localparam int N  = LANES + OFF;
  localparam int PW = idx_w(N);
  localparam int BW = $clog2(NUM_IN + LANES) + 1;

  state_e                   st;
  logic signed [DATA_W-1:0] snap    [NUM_IN];
  logic signed [DATA_W-1:0] snap_sh [NUM_IN];
  logic [BW-1:0]            base;     // index of snap[0] in the original vector
  logic signed [DATA_W-1:0] acc_val;
  logic [IDX_W-1:0]         acc_idx;

  logic [N-1:0][DATA_W-1:0] cand_val;
  logic [N-1:0]             cand_vld;
  logic [DATA_W-1:0]        t_val;
  logic [PW-1:0]            t_pos;
  logic [IDX_W-1:0]         win_idx;
  logic                     last;

  // Running best sits at position 0 so it wins ties against later lanes.
  assign cand_val[0] = acc_val;
  assign cand_vld[0] = (base != '0);

`ifdef SELECT_MAX_MARGIN_EN
  logic signed [DATA_W-1:0] acc2_val;
  logic                     acc2_vld;
  logic [DATA_W-1:0]        s_val;
  logic                     s_vld;

  assign cand_val[1] = acc2_val;
  assign cand_vld[1] = acc2_vld && (base != '0);
`endif

  // Snapshot is consumed front-first; each lane reads a fixed slot and
  // lanes beyond the vector end are masked off.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign cand_val[OFF+l] = snap[l];
    assign cand_vld[OFF+l] = (int'(base) + l < NUM_IN);
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_shift
    if (i + LANES < NUM_IN) begin : g_mv
      assign snap_sh[i] = snap[i+LANES];
    end else begin : g_zero
      assign snap_sh[i] = '0;
    end
  end

  select_max_lane_tree #(.DATA_W(DATA_W), .N(N)) u_tree (
    .val     (cand_val),
    .vld     (cand_vld),
    .top_val (t_val),
    .top_pos (t_pos)
`ifdef SELECT_MAX_MARGIN_EN
    ,
    .sec_val (s_val),
    .sec_vld (s_vld)
`endif
  );

  assign win_idx = (t_pos == '0) ? acc_idx
                                 : IDX_W'(int'(base) + int'(t_pos) - OFF);
  assign last    = (int'(base) + LANES >= NUM_IN);

  // Control FSM with registered outputs; results land only on DONE entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st             <= IDLE;
      snap           <= '{default: '0};
      base           <= '0;
      acc_val        <= '0;
      acc_idx        <= '0;
      bus.busy       <= 1'b0;
      bus.layer_done <= 1'b0;
      bus.max        <= '0;
      bus.digit      <= '0;
`ifdef SELECT_MAX_MARGIN_EN
      acc2_val       <= '0;
      acc2_vld       <= 1'b0;
      bus.runner_up  <= '0;
      bus.margin     <= '0;
`endif
    end else begin
      bus.layer_done <= 1'b0;
      case (st)
        IDLE: if (bus.start) begin
          snap     <= bus.in_data;
          base     <= '0;
          bus.busy <= 1'b1;
          st       <= SCAN;
        end
        SCAN: if (bus.enable) begin
          snap    <= snap_sh;
          base    <= base + BW'(LANES);
          acc_val <= t_val;
          acc_idx <= win_idx;
`ifdef SELECT_MAX_MARGIN_EN
          acc2_val <= s_val;
          acc2_vld <= s_vld;
`endif
          if (last) begin
            st             <= DONE;
            bus.busy       <= 1'b0;
            bus.layer_done <= 1'b1;
            bus.max        <= t_val;
            bus.digit      <= win_idx;
`ifdef SELECT_MAX_MARGIN_EN
            bus.runner_up  <= s_val;
            bus.margin     <= {t_val[DATA_W-1], t_val} - {s_val[DATA_W-1], s_val};
`endif
          end
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule
